// File: rtl/video_pll_pkg.sv
// Shared constants, lock state and period check for the behavioural video PLL.
// No logic; no latency and no backpressure.
package video_pll_pkg;

    localparam real CLKIN_FREQ = 50.0;
    localparam int  REF_PERIOD = 10;
    localparam int  PERIOD_TOL = 1;
    localparam int  LOCK_CNT   = 64;
    localparam int  LOSS_CNT   = 4;
    localparam int  CNT_W      = 8;
    localparam int  DIV0       = 4;
    localparam int  DIV1       = 10;
    localparam int  DIV2       = 20;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    function automatic logic is_good_period(input int cnt, input int ref_p, input int tol);
        return (cnt >= ref_p - tol) && (cnt <= ref_p + tol);
    endfunction

endpackage

// File: rtl/video_pll_clk_div.sv
// Even divider, 50% duty; first rise DIV/2 cycles after en rises.
// Output held low while en=0; no backpressure.
module video_pll_clk_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic clk_o
);

    localparam int HALF = DIV / 2;
    localparam int W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [W-1:0] LAST = W'(HALF - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            clk_o <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            clk_o <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            clk_o <= ~clk_o;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/video_pll_gen.sv
// Qualifies clkin1 by period measurement, raises pll_lock, then gates three divided clocks.
// Lock after ~(LOCK_CNT+1)*REF_PERIOD+4 cycles; no backpressure.
module video_pll_gen
    import video_pll_pkg::*;
#(
    parameter int REF_PERIOD = video_pll_pkg::REF_PERIOD,
    parameter int PERIOD_TOL = video_pll_pkg::PERIOD_TOL,
    parameter int LOCK_CNT   = video_pll_pkg::LOCK_CNT,
    parameter int LOSS_CNT   = video_pll_pkg::LOSS_CNT,
    parameter int CNT_W      = video_pll_pkg::CNT_W,
    parameter int DIV0       = video_pll_pkg::DIV0,
    parameter int DIV1       = video_pll_pkg::DIV1,
    parameter int DIV2       = video_pll_pkg::DIV2
) (
    input  logic clk_tb,
    input  logic rst_n,
    input  logic clkin1,
    input  logic pll_rst,
    output logic clkout0,
    output logic clkout1,
    output logic clkout2,
    output logic pll_lock
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [GW-1:0]    GOOD_LAST = GW'(LOCK_CNT);
    localparam logic [BW-1:0]    BAD_LAST  = BW'(LOSS_CNT - 1);

    logic             ir_async;
    logic [1:0]       rst_sync;
    logic             ir_n;
    logic [2:0]       ck_sync;
    logic             rise;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic             started;
    logic             sat;
    logic             timeout;
    logic             ev_good;
    logic             ev_bad;
    lock_state_t      state;
    logic [GW-1:0]    good_cnt;
    logic [BW-1:0]    bad_cnt;

    // Either reset source asserts immediately; release waits two clk_tb edges.
    assign ir_async = !rst_n || pll_rst;

    always_ff @(posedge clk_tb or posedge ir_async) begin
        if (ir_async) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign ir_n = rst_sync[1];

    always_ff @(posedge clk_tb or negedge ir_n) begin
        if (!ir_n) ck_sync <= '0;
        else       ck_sync <= {ck_sync[1:0], clkin1};
    end

    assign rise = ck_sync[1] && !ck_sync[2];
    assign sat  = (per_cnt == CNT_MAX);

    // A stalled clkin1 yields one bad period on saturation and every CNT_MAX cycles after.
    assign timeout = started && sat && !rise && (miss_cnt == '0);
    assign ev_good = rise && started && !sat &&
                     is_good_period(int'(per_cnt), REF_PERIOD, PERIOD_TOL);
    assign ev_bad  = (rise && started && !ev_good) || timeout;

    always_ff @(posedge clk_tb or negedge ir_n) begin
        if (!ir_n) begin
            per_cnt  <= '0;
            miss_cnt <= '0;
            started  <= 1'b0;
        end else if (rise) begin
            per_cnt  <= CNT_W'(1);
            miss_cnt <= '0;
            started  <= 1'b1;
        end else if (!sat) begin
            per_cnt  <= per_cnt + 1'b1;
        end else if (miss_cnt == CNT_MAX - 1'b1) begin
            miss_cnt <= '0;
        end else begin
            miss_cnt <= miss_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_tb or negedge ir_n) begin
        if (!ir_n) begin
            state    <= UNLOCKED;
            good_cnt <= '0;
            bad_cnt  <= '0;
            pll_lock <= 1'b0;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (good_cnt == GOOD_LAST) begin
                        state    <= LOCKED;
                        pll_lock <= 1'b1;
                        bad_cnt  <= '0;
                    end else if (ev_good) begin
                        good_cnt <= good_cnt + 1'b1;
                    end else if (ev_bad) begin
                        good_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (ev_bad) begin
                        if (bad_cnt == BAD_LAST) begin
                            state    <= UNLOCKED;
                            pll_lock <= 1'b0;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            bad_cnt  <= bad_cnt + 1'b1;
                        end
                    end else if (ev_good) begin
                        bad_cnt <= '0;
                    end
                end
                default: begin
                    state    <= UNLOCKED;
                    pll_lock <= 1'b0;
                end
            endcase
        end
    end

    video_pll_clk_div #(.DIV(DIV0)) u_div0 (
        .clk   (clk_tb),
        .rst_n (ir_n),
        .en    (pll_lock),
        .clk_o (clkout0)
    );

    video_pll_clk_div #(.DIV(DIV1)) u_div1 (
        .clk   (clk_tb),
        .rst_n (ir_n),
        .en    (pll_lock),
        .clk_o (clkout1)
    );

    video_pll_clk_div #(.DIV(DIV2)) u_div2 (
        .clk   (clk_tb),
        .rst_n (ir_n),
        .en    (pll_lock),
        .clk_o (clkout2)
    );

endmodule

// File: tb/tb_video_pll_gen.sv
// Directed bench for video_pll_gen: lock latency, divider timing, reset, loss and off-frequency cases.
`timescale 1ns/1ps
module tb_video_pll_gen;

    logic clk_tb  = 1'b0;
    logic rst_n   = 1'b0;
    logic clkin1  = 1'b0;
    logic pll_rst = 1'b0;
    logic clkout0, clkout1, clkout2, pll_lock;

    real clkin_half = 10.0;
    bit  clkin_en   = 1'b1;

    int total = 0;
    int bad   = 0;
    int lock_rises = 0;
    int lock_falls = 0;
    int xerr = 0;

    typedef struct {
        string tag;
        int    lo;
        int    hi;
    } exp_t;

    exp_t exp_q[$];
    logic [2:0] samp [64];

    video_pll_gen dut (
        .clk_tb   (clk_tb),
        .rst_n    (rst_n),
        .clkin1   (clkin1),
        .pll_rst  (pll_rst),
        .clkout0  (clkout0),
        .clkout1  (clkout1),
        .clkout2  (clkout2),
        .pll_lock (pll_lock)
    );

    always #1 clk_tb = ~clk_tb;

    initial begin
        #0.3;
        forever begin
            if (clkin_en) begin
                #(clkin_half) clkin1 = ~clkin1;
            end else begin
                clkin1 = 1'b0;
                #1;
            end
        end
    end

    always @(posedge pll_lock) lock_rises++;
    always @(negedge pll_lock) lock_falls++;
    always @(negedge clk_tb)
        if (rst_n && $isunknown({pll_lock, clkout0, clkout1, clkout2})) xerr++;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input string tag, input int lo, input int hi);
        exp_t e;
        e.tag = tag;
        e.lo  = lo;
        e.hi  = hi;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int obs);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=entry", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs >= e.lo && obs <= e.hi) else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d..%0d", e.tag, obs, e.lo, e.hi);
            end
        end
    endtask

    task automatic wait_lock(input logic want, input int budget, output int cyc);
        cyc = 0;
        while (pll_lock !== want && cyc < budget) begin
            @(negedge clk_tb);
            cyc++;
        end
        if (pll_lock !== want) cyc = -1;
    endtask

    task automatic pulse_pll_rst();
        @(negedge clk_tb);
        #0.5 pll_rst = 1'b1;
        #20  pll_rst = 1'b0;
    endtask

    function automatic int find_from(input int ch, input int from, input logic val);
        if (from < 0) return -1;
        for (int k = from; k < 64; k++)
            if (samp[k][ch] === val) return k;
        return -1;
    endfunction

    initial begin
        int lat;
        int r1, f1, r2;
        int lhi, chi;
        int div_c [3];
        int per_ns [3];
        div_c  = '{4, 10, 20};
        per_ns = '{8, 20, 40};

        // reset state
        #10;
        push("reset_lock", 0, 0);
        push("reset_clkouts", 0, 0);
        pop_check(int'(pll_lock));
        pop_check(int'({clkout2, clkout1, clkout0}));
        #10 rst_n = 1'b1;
        #20 pll_rst = 1'b1;
        #10;
        push("pllrst_lock", 0, 0);
        pop_check(int'(pll_lock));
        #10 pll_rst = 1'b0;

        // scenario 1: nominal 50 MHz lock
        push("s1_lock_latency", 646, 653);
        wait_lock(1'b1, 2000, lat);
        for (int k = 0; k < 64; k++) begin
            samp[k] = {clkout2, clkout1, clkout0};
            @(negedge clk_tb);
        end
        pop_check(lat);
        push("s1_lock_rises", 1, 1);
        pop_check(lock_rises);

        // scenario 2: divider timing measured from the lock cycle
        for (int ch = 0; ch < 3; ch++) begin
            push($sformatf("s2_first_rise_%0d", ch), div_c[ch] / 2, div_c[ch] / 2);
            push($sformatf("s2_high_ns_%0d", ch), per_ns[ch] / 2, per_ns[ch] / 2);
            push($sformatf("s2_period_ns_%0d", ch), per_ns[ch], per_ns[ch]);
            r1 = find_from(ch, 0, 1'b1);
            f1 = find_from(ch, r1, 1'b0);
            r2 = find_from(ch, f1, 1'b1);
            pop_check(r1);
            pop_check((r1 < 0 || f1 < 0) ? -1 : (f1 - r1) * 2);
            pop_check((r1 < 0 || r2 < 0) ? -1 : (r2 - r1) * 2);
        end

        push("s1_lock_held", 1, 1);
        push("s1_no_fall", 0, 0);
        repeat (5000) @(negedge clk_tb);
        pop_check(int'(pll_lock));
        pop_check(lock_falls);

        // scenario 3: pll_rst while locked clears outputs asynchronously
        @(negedge clk_tb);
        #0.5 pll_rst = 1'b1;
        #0.1;
        push("s3_async_lock", 0, 0);
        push("s3_async_clk", 0, 0);
        pop_check(int'(pll_lock));
        pop_check(int'({clkout2, clkout1, clkout0}));
        #19.4 pll_rst = 1'b0;
        push("s3_relock", 640, 660);
        wait_lock(1'b1, 2000, lat);
        pop_check(lat);

        // scenario 4: missing reference clock
        repeat (100) @(negedge clk_tb);
        clkin_en = 1'b0;
        push("s4_loss_latency", 995, 1050);
        wait_lock(1'b0, 3000, lat);
        pop_check(lat);
        repeat (2) @(negedge clk_tb);
        push("s4_clk_low", 0, 0);
        pop_check(int'({clkout2, clkout1, clkout0}));
        clkin_en = 1'b1;
        push("s4_relock", 645, 655);
        wait_lock(1'b1, 2000, lat);
        pop_check(lat);

        // scenario 5a: 40 MHz is out of tolerance
        clkin_half = 12.5;
        pulse_pll_rst();
        lhi = 0;
        chi = 0;
        repeat (2500) begin
            @(negedge clk_tb);
            if (pll_lock !== 1'b0) lhi++;
            if ({clkout2, clkout1, clkout0} !== 3'b000) chi++;
        end
        push("s5_40m_lock_cycles", 0, 0);
        push("s5_40m_clk_cycles", 0, 0);
        pop_check(lhi);
        pop_check(chi);

        // scenario 5b: 11-cycle period is within tolerance
        clkin_half = 11.0;
        pulse_pll_rst();
        push("s5_45m_lock", 705, 735);
        wait_lock(1'b1, 2500, lat);
        pop_check(lat);

        push("x_free", 0, 0);
        pop_check(xerr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
